// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_DISPENSE,
    ST_CHANGE
  } vend_state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_TWO  = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  localparam int unsigned VAL_ONE = 1;
  localparam int unsigned VAL_TWO = 2;

endpackage

// File: rtl/vend_if.sv
// Dispense-motor and change-hopper req/ack handshakes.
interface vend_if #(
  parameter int unsigned SLOT_W = 2
) ();
  logic              disp_req;
  logic [SLOT_W-1:0] disp_slot;
  logic              disp_ack;
  logic              chg_req;
  logic [1:0]        chg_coin;
  logic              chg_ack;

  modport master (
    output disp_req, disp_slot, chg_req, chg_coin,
    input  disp_ack, chg_ack
  );

  modport slave (
    input  disp_req, disp_slot, chg_req, chg_coin,
    output disp_ack, chg_ack
  );
endinterface

// File: rtl/vend_slot_table.sv
// Per-slot price/stock storage: one async read port, one config write port,
// and a single-slot stock decrement/increment path.
module vend_slot_table #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned CREDIT_W  = 4,
  parameter int unsigned STOCK_W   = 4,
  localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SLOT_W-1:0]   rd_slot,
  output logic [CREDIT_W-1:0] rd_price,
  output logic [STOCK_W-1:0]  rd_stock,
  input  logic                we,
  input  logic [SLOT_W-1:0]   wr_slot,
  input  logic [CREDIT_W-1:0] wr_price,
  input  logic [STOCK_W-1:0]  wr_stock,
  input  logic                dec,
  input  logic                inc,
  input  logic [SLOT_W-1:0]   upd_slot
);

  logic [CREDIT_W-1:0] price [NUM_SLOTS];
  logic [STOCK_W-1:0]  stock [NUM_SLOTS];

  // A config write lands after the stock update so it wins on a same-slot clash.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      price <= '{default: '0};
      stock <= '{default: '0};
    end else begin
      if (dec)
        stock[upd_slot] <= stock[upd_slot] - STOCK_W'(1);
      else if (inc)
        stock[upd_slot] <= stock[upd_slot] + STOCK_W'(1);
      if (we) begin
        price[wr_slot] <= wr_price;
        stock[wr_slot] <= wr_stock;
      end
    end
  end

  assign rd_price = price[rd_slot];
  assign rd_stock = stock[rd_slot];

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: coin credit, price/stock check, dispense handshake with
// timeout recovery, and coin-by-coin change payout.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 4,
  parameter int unsigned CREDIT_W     = 4,
  parameter int unsigned STOCK_W      = 4,
  parameter int unsigned DISP_TIMEOUT = 15,
  localparam int unsigned SLOT_W      = $clog2(NUM_SLOTS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coinn,
  input  logic                cancel,
  input  logic                sel_valid,
  input  logic [SLOT_W-1:0]   sel_slot,
  input  logic                cfg_we,
  input  logic [SLOT_W-1:0]   cfg_slot,
  input  logic [CREDIT_W-1:0] cfg_price,
  input  logic [STOCK_W-1:0]  cfg_stock,
  vend_if.master              bus,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_rej,
  output logic                sel_nack,
  output logic                sold_out,
  output logic                fault
);

  localparam int unsigned TMO_W = $clog2(DISP_TIMEOUT + 1);
  localparam int unsigned CW1   = CREDIT_W + 1;

  vend_state_e state, state_n;
  logic [CREDIT_W-1:0] credit_r, credit_n;
  logic [TMO_W-1:0]    tmo, tmo_n;
  logic                disp_req_r, disp_req_n;
  logic [SLOT_W-1:0]   disp_slot_r, disp_slot_n;
  logic                chg_req_r, chg_req_n;
  logic [1:0]          chg_coin_r, chg_coin_n;
  logic                coin_rej_r, coin_rej_n;
  logic                sel_nack_r, sel_nack_n;
  logic                sold_out_r, sold_out_n;
  logic                fault_r, fault_n;

  logic [SLOT_W-1:0]   rd_slot;
  logic [CREDIT_W-1:0] rd_price;
  logic [STOCK_W-1:0]  rd_stock;
  logic                tbl_we, tbl_dec, tbl_inc;

  logic [CW1-1:0]      coin_val, credit_sum;
  logic                coin_seen, coin_take;
  logic [CREDIT_W-1:0] chg_val;

  vend_slot_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .CREDIT_W  (CREDIT_W),
    .STOCK_W   (STOCK_W)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .rd_slot  (rd_slot),
    .rd_price (rd_price),
    .rd_stock (rd_stock),
    .we       (tbl_we),
    .wr_slot  (cfg_slot),
    .wr_price (cfg_price),
    .wr_stock (cfg_stock),
    .dec      (tbl_dec),
    .inc      (tbl_inc),
    .upd_slot (rd_slot)
  );

  always_comb begin
    coin_val = '0;
    if (coinn == COIN_ONE) coin_val = CW1'(VAL_ONE);
    if (coinn == COIN_TWO) coin_val = CW1'(VAL_TWO);
    coin_seen  = (coinn != COIN_NONE);
    credit_sum = {1'b0, credit_r} + coin_val;
    // Overflow is judged against the pre-sale credit so a later timeout refund always fits.
    coin_take  = (coinn == COIN_ONE || coinn == COIN_TWO) && !credit_sum[CREDIT_W];
    chg_val    = (chg_coin_r == COIN_TWO) ? CREDIT_W'(VAL_TWO) : CREDIT_W'(VAL_ONE);
    rd_slot    = (state == ST_DISPENSE) ? disp_slot_r : sel_slot;
  end

  always_comb begin
    state_n     = state;
    credit_n    = credit_r;
    tmo_n       = tmo;
    disp_req_n  = disp_req_r;
    disp_slot_n = disp_slot_r;
    chg_req_n   = chg_req_r;
    chg_coin_n  = chg_coin_r;
    coin_rej_n  = 1'b0;
    sel_nack_n  = 1'b0;
    sold_out_n  = 1'b0;
    fault_n     = 1'b0;
    tbl_we      = 1'b0;
    tbl_dec     = 1'b0;
    tbl_inc     = 1'b0;

    unique case (state)
      ST_IDLE, ST_CREDIT: begin
        coin_rej_n = coin_seen && !coin_take;
        if (coin_take) credit_n = credit_sum[CREDIT_W-1:0];
        tbl_we = cfg_we && (state == ST_IDLE);
        if (state == ST_CREDIT && cancel) begin
          state_n = ST_CHANGE;
        end else if (sel_valid &&
                     (state == ST_CREDIT || (rd_price == '0 && rd_stock != '0))) begin
          if (rd_stock == '0) begin
            sold_out_n = 1'b1;
          end else if (credit_r < rd_price) begin
            sel_nack_n = 1'b1;
          end else begin
            credit_n    = credit_r - rd_price + (coin_take ? coin_val[CREDIT_W-1:0] : '0);
            tbl_dec     = 1'b1;
            disp_slot_n = sel_slot;
            disp_req_n  = 1'b1;
            tmo_n       = '0;
            state_n     = ST_DISPENSE;
          end
        end else if (coin_take && state == ST_IDLE) begin
          state_n = ST_CREDIT;
        end
      end

      ST_DISPENSE: begin
        coin_rej_n = coin_seen;
        if (bus.disp_ack) begin
          disp_req_n = 1'b0;
          state_n    = (credit_r != '0) ? ST_CHANGE : ST_IDLE;
        end else if (tmo == TMO_W'(DISP_TIMEOUT - 1)) begin
          fault_n    = 1'b1;
          disp_req_n = 1'b0;
          credit_n   = credit_r + rd_price;
          tbl_inc    = 1'b1;
          state_n    = ST_CHANGE;
        end else begin
          tmo_n = tmo + TMO_W'(1);
        end
      end

      ST_CHANGE: begin
        coin_rej_n = coin_seen;
        if (chg_req_r) begin
          if (bus.chg_ack) begin
            credit_n  = credit_r - chg_val;
            chg_req_n = 1'b0;
            if (credit_n == '0) state_n = ST_IDLE;
          end
        end else if (credit_r == '0) begin
          state_n = ST_IDLE;
        end else begin
          chg_req_n  = 1'b1;
          chg_coin_n = (credit_r >= CREDIT_W'(VAL_TWO)) ? COIN_TWO : COIN_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      credit_r    <= '0;
      tmo         <= '0;
      disp_req_r  <= 1'b0;
      disp_slot_r <= '0;
      chg_req_r   <= 1'b0;
      chg_coin_r  <= COIN_NONE;
      coin_rej_r  <= 1'b0;
      sel_nack_r  <= 1'b0;
      sold_out_r  <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state       <= state_n;
      credit_r    <= credit_n;
      tmo         <= tmo_n;
      disp_req_r  <= disp_req_n;
      disp_slot_r <= disp_slot_n;
      chg_req_r   <= chg_req_n;
      chg_coin_r  <= chg_coin_n;
      coin_rej_r  <= coin_rej_n;
      sel_nack_r  <= sel_nack_n;
      sold_out_r  <= sold_out_n;
      fault_r     <= fault_n;
    end
  end

  assign bus.disp_req  = disp_req_r;
  assign bus.disp_slot = disp_slot_r;
  assign bus.chg_req   = chg_req_r;
  assign bus.chg_coin  = chg_coin_r;
  assign credit        = credit_r;
  assign coin_rej      = coin_rej_r;
  assign sel_nack      = sel_nack_r;
  assign sold_out      = sold_out_r;
  assign fault         = fault_r;

endmodule
